// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Purpose  : Synchronous modulo-MODULUS up/down counter with enable, parallel
//            load (clamped to MODULUS-1), terminal count, wrap pulse and a
//            one-shot mode that halts at terminal count.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            en, up        - count enable, direction (1 = up)
//            load,load_val - parallel load strobe and value
//            oneshot       - 1 = stop at terminal count, 0 = wrap
//            Q, Qbar       - registered count and its complement
//            tc            - combinational terminal count
//            wrap          - one-cycle pulse on wrap or one-shot completion
//            halted        - one-shot has completed
//            gray          - Gray-coded Q (only when GRAY_OUT_EN is defined)
// Options  : GRAY_OUT_EN   - adds the gray output port
// Revision : 1.0 - initial synchronous parametrised release
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc,
    output logic             wrap,
    output logic             halted
`ifdef GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    generate
        if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
            $error("param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
    localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH + 1)'(MODULUS);

    state_t           r_state_q;
    state_t           w_state_d;
    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             r_wrap_q;
    logic             w_wrap_d;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_tc;

    assign w_term         = up ? c_MAX : '0;
    assign w_tc           = (r_state_q == ST_RUN) && en && (r_count_q == w_term);
    assign w_load_clamped = ({1'b0, load_val} < c_MOD_EXT) ? load_val : c_MAX;

    always_comb begin
        w_count_d = r_count_q;
        w_state_d = r_state_q;
        w_wrap_d  = 1'b0;
        if (load) begin
            w_count_d = w_load_clamped;
            w_state_d = ST_RUN;
        end else if ((r_state_q == ST_RUN) && en) begin
            if (w_tc) begin
                w_wrap_d = 1'b1;
                if (oneshot) begin
                    // Completion: hold the terminal value and park in HALT.
                    w_state_d = ST_HALT;
                end else begin
                    w_count_d = up ? '0 : c_MAX;
                end
            end else begin
                // Terminal value is excluded above, so no binary overflow here.
                w_count_d = up ? (r_count_q + WIDTH'(1)) : (r_count_q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
            r_state_q <= ST_RUN;
            r_wrap_q  <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_state_q <= w_state_d;
            r_wrap_q  <= w_wrap_d;
        end
    end

    assign Q      = r_count_q;
    assign Qbar   = ~r_count_q;
    assign tc     = w_tc;
    assign wrap   = r_wrap_q;
    assign halted = (r_state_q == ST_HALT);

`ifdef GRAY_OUT_EN
    // Single-bit change at wrap holds only when MODULUS is a power of two.
    assign gray = r_count_q ^ (r_count_q >> 1);
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Purpose  : Scoreboard bench for param_updown_counter. Three instances:
//            A (WIDTH=3, MODULUS=8), B (WIDTH=4, MODULUS=10),
//            C (WIDTH=1, MODULUS=2). Directed vectors push expected results
//            into a queue; a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b1, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0, a_os = 1'b0;
    logic [2:0] a_lv = '0;
    logic [2:0] a_q, a_qb;
    logic       a_tc, a_wrap, a_halt;

    logic       b_rst = 1'b1, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0, b_os = 1'b0;
    logic [3:0] b_lv = '0;
    logic [3:0] b_q, b_qb;
    logic       b_tc, b_wrap, b_halt;

    logic       c_rst = 1'b1, c_en = 1'b0, c_up = 1'b0, c_load = 1'b0, c_os = 1'b0;
    logic [0:0] c_lv = '0;
    logic [0:0] c_q, c_qb;
    logic       c_tc, c_wrap, c_halt;

`ifdef GRAY_OUT_EN
    logic [2:0] a_gray;
    logic [3:0] b_gray;
    logic [0:0] c_gray;
`endif

    param_updown_counter #(.WIDTH(3), .MODULUS(8)) u_dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_lv), .oneshot(a_os), .Q(a_q), .Qbar(a_qb),
        .tc(a_tc), .wrap(a_wrap), .halted(a_halt)
`ifdef GRAY_OUT_EN
        , .gray(a_gray)
`endif
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_lv), .oneshot(b_os), .Q(b_q), .Qbar(b_qb),
        .tc(b_tc), .wrap(b_wrap), .halted(b_halt)
`ifdef GRAY_OUT_EN
        , .gray(b_gray)
`endif
    );

    param_updown_counter #(.WIDTH(1), .MODULUS(2)) u_dut_c (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load),
        .load_val(c_lv), .oneshot(c_os), .Q(c_q), .Qbar(c_qb),
        .tc(c_tc), .wrap(c_wrap), .halted(c_halt)
`ifdef GRAY_OUT_EN
        , .gray(c_gray)
`endif
    );

    typedef struct {
        int         id;
        logic       exp_tc;
        logic [3:0] exp_q;
        logic       exp_wrap;
        logic       exp_halt;
    } item_t;

    item_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // One stimulus cycle: inputs for DUT 'id' plus the tc expected before the
    // edge and the Q/wrap/halted expected after it.
    task automatic drive(input int id, input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv, input logic os,
                         input logic tc_e, input logic [3:0] q_e,
                         input logic w_e, input logic h_e);
        item_t it;
        @(negedge clk);
        case (id)
            0: begin a_rst = r; a_en = e; a_up = u; a_load = l; a_lv = lv[2:0]; a_os = os; end
            1: begin b_rst = r; b_en = e; b_up = u; b_load = l; b_lv = lv;      b_os = os; end
            default: begin c_rst = r; c_en = e; c_up = u; c_load = l; c_lv = lv[0:0]; c_os = os; end
        endcase
        it.id = id; it.exp_tc = tc_e; it.exp_q = q_e; it.exp_wrap = w_e; it.exp_halt = h_e;
        sb_q.push_back(it);
    endtask

    // Monitor: tc checked mid-cycle with inputs settled, registered outputs
    // checked just after the following rising edge.
    initial begin
        item_t      it;
        logic [3:0] q4, qb4;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.id)
                    0: check("tc_a", {3'b0, a_tc}, {3'b0, it.exp_tc});
                    1: check("tc_b", {3'b0, b_tc}, {3'b0, it.exp_tc});
                    default: check("tc_c", {3'b0, c_tc}, {3'b0, it.exp_tc});
                endcase
                @(posedge clk);
                #1;
                case (it.id)
                    0: begin
                        q4 = {1'b0, a_q}; qb4 = {1'b0, a_qb};
                        check("q_a", q4, it.exp_q);
                        check("qbar_a", qb4, {1'b0, ~it.exp_q[2:0]});
                        check("wrap_a", {3'b0, a_wrap}, {3'b0, it.exp_wrap});
                        check("halted_a", {3'b0, a_halt}, {3'b0, it.exp_halt});
`ifdef GRAY_OUT_EN
                        check("gray_a", {1'b0, a_gray},
                              {1'b0, it.exp_q[2:0] ^ {1'b0, it.exp_q[2:1]}});
`endif
                    end
                    1: begin
                        check("q_b", b_q, it.exp_q);
                        check("qbar_b", b_qb, ~it.exp_q);
                        check("wrap_b", {3'b0, b_wrap}, {3'b0, it.exp_wrap});
                        check("halted_b", {3'b0, b_halt}, {3'b0, it.exp_halt});
                    end
                    default: begin
                        check("q_c", {3'b0, c_q}, it.exp_q);
                        check("qbar_c", {3'b0, c_qb}, {3'b0, ~it.exp_q[0]});
                        check("wrap_c", {3'b0, c_wrap}, {3'b0, it.exp_wrap});
                        check("halted_c", {3'b0, c_halt}, {3'b0, it.exp_halt});
                    end
                endcase
            end
        end
    end

    initial begin
        int a_post[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        int a_flag[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int b_post[11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
        int b_flag[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        int guard;

        repeat (2) @(negedge clk);

        // ---- A: WIDTH=3, MODULUS=8 ----
        drive(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // reset state
        drive(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0);   // en=0 holds
        for (int i = 0; i < 10; i++)
            drive(0, 0, 1, 1, 0, 0, 0, a_flag[i][0], a_post[i][3:0], a_flag[i][0], 0);
        drive(0, 0, 1, 1, 1, 5, 0,  0, 5, 0, 0);   // load, no increment
        drive(0, 0, 1, 1, 0, 0, 1,  0, 6, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 1,  0, 7, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 1,  1, 7, 1, 1);   // one-shot completion
        drive(0, 0, 1, 1, 0, 0, 1,  0, 7, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 1,  0, 7, 0, 1);   // en toggling ignored
        drive(0, 0, 1, 1, 0, 0, 0,  0, 7, 0, 1);   // oneshot=0 stays halted
        drive(0, 0, 1, 0, 0, 0, 0,  0, 7, 0, 1);   // up ignored in HALT
        drive(0, 0, 1, 1, 1, 2, 1,  0, 2, 0, 0);   // load leaves HALT
        drive(0, 0, 1, 1, 0, 0, 0,  0, 3, 0, 0);   // counting resumes
        drive(0, 0, 1, 1, 1, 7, 0,  0, 7, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0,  0, 6, 0, 0);   // flip at MAX: no wrap
        drive(0, 1, 1, 1, 1, 5, 0,  0, 0, 0, 0);   // rst beats load
        drive(0, 0, 1, 1, 1, 7, 1,  0, 7, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 1,  1, 7, 1, 1);
        drive(0, 1, 1, 1, 0, 0, 1,  0, 0, 0, 0);   // rst while halted
        drive(0, 0, 1, 1, 0, 0, 0,  0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // park A in reset

        // ---- B: WIDTH=4, MODULUS=10 ----
        drive(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        for (int i = 0; i < 11; i++)
            drive(1, 0, 1, 0, 0, 0, 0, b_flag[i][0], b_post[i][3:0], b_flag[i][0], 0);
        drive(1, 0, 1, 0, 1, 7, 0,  0, 7, 0, 0);   // load, no decrement
        drive(1, 0, 1, 1, 0, 0, 0,  0, 8, 0, 0);
        drive(1, 0, 1, 1, 1, 13, 0, 0, 9, 0, 0);   // clamp 13 -> 9
        drive(1, 0, 1, 1, 0, 0, 0,  1, 0, 1, 0);   // up wrap at 9
        drive(1, 0, 1, 1, 1, 15, 0, 0, 9, 0, 0);   // clamp 15 -> 9
        drive(1, 0, 1, 0, 1, 1, 1,  0, 1, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 1,  1, 0, 1, 1);   // one-shot down completes
        drive(1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // ---- C: WIDTH=1, MODULUS=2, back-to-back wraps ----
        drive(2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        drive(2, 0, 1, 0, 0, 0, 0,  1, 1, 1, 0);
        drive(2, 0, 1, 1, 0, 0, 0,  1, 0, 1, 0);
        drive(2, 0, 1, 0, 0, 0, 0,  1, 1, 1, 0);
        drive(2, 0, 1, 1, 0, 0, 0,  1, 0, 1, 0);

        guard = 0;
        while ((sb_q.size() > 0) && (guard < 20)) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d items left, expected 0", sb_q.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Synchronous, parametrised successor to the team's 3-bit ripple up counter: one clock domain, no ripple stages.
- Counts modulo MODULUS in either direction, with enable, parallel load, a wrap/terminal-count indication and a one-shot mode that stops at terminal count.
- Used as a general counter/timer primitive in datapath and control blocks; keeps the complementary Qbar output of the earlier counter.

Parameters:
- WIDTH, 3, counter width in bits.
- MODULUS, 8, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  load value.
- oneshot  input  1  1 = stop at terminal count; 0 = wrap around.
- Q  output  WIDTH  count value (registered).
- Qbar  output  WIDTH  ~Q.
- tc  output  1  terminal count, combinational.
- wrap  output  1  one-cycle registered pulse on wrap or one-shot completion.
- halted  output  1  one-shot has completed (registered).

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. No asynchronous paths.
- Reset values: Q=0, Qbar=all ones, wrap=0, halted=0. State after reset is RUN.
- Priority per edge: rst > load > count.
- States: RUN and HALT.
  - halted=1 exactly when the state is HALT.
- Load (load=1, rst=0), from any state:
  - Q <= load_val if load_val < MODULUS; otherwise Q <= MODULUS-1 (clamp).
  - State becomes RUN, halted <= 0, wrap <= 0.
  - en is ignored in that cycle.
- Terminal value for the current direction:
  - up=1: MODULUS-1.
  - up=0: 0.
- tc = RUN & en & (Q == terminal value for current up). tc follows up and en combinationally in the same cycle.
- Count in RUN with en=1, oneshot=0:
  - up=1: Q <= Q+1; if Q==MODULUS-1, Q <= 0 and wrap <= 1.
  - up=0: Q <= Q-1; if Q==0, Q <= MODULUS-1 and wrap <= 1.
- Count in RUN with en=1, oneshot=1:
  - Same as above, except when tc=1: Q holds its value, state becomes HALT, halted <= 1, wrap <= 1.
- RUN with en=0: Q holds, wrap <= 0.
- HALT:
  - Q holds; en, up and oneshot are ignored; wrap <= 0 after the entry cycle.
  - Leaves HALT only via load (to RUN) or rst.
  - Deasserting oneshot does not leave HALT.
- wrap is high for exactly one cycle per wrap or completion event. Back-to-back wraps when MODULUS=2 give wrap high on consecutive cycles.
- A direction change takes effect on the next edge with no pipeline bubble.
- Arithmetic: WIDTH-bit. Intermediate values never exceed MODULUS-1, so there is no binary overflow even when MODULUS < 2**WIDTH.
- Qbar is bitwise ~Q at all times, including during reset.

Optional Feature:
- Macro: GRAY_OUT_EN.
- Defined:
  - Adds output port gray (WIDTH bits) = Q ^ (Q >> 1), combinational from Q.
  - Reset value 0.
  - When MODULUS is not a power of two, gray is not guaranteed to be single-bit-change at wrap; this is documented and not checked.
- Undefined: no gray port and no related logic. All other behaviour is identical.

Test Plan:
- WIDTH=3, MODULUS=8; rst for 1 cycle, then en=1, up=1, oneshot=0 for 10 cycles:
  - Q sequence 1,2,...,7,0,1,2.
  - wrap high only in the cycle Q shows 0.
  - tc high while Q=7.
  - Qbar = ~Q throughout.
- WIDTH=4, MODULUS=10; up=0 from reset:
  - Q sequence 9,8,...,0,9.
  - wrap pulses on the 0->9 transition.
  - tc high while Q=0.
- WIDTH=4, MODULUS=10:
  - load=1, load_val=7 with en=1 -> Q=7 next cycle, no increment in the load cycle.
  - load_val=13 -> Q=9 (clamp).
- WIDTH=3, MODULUS=8, oneshot=1, up=1, from Q=5:
  - Q=6, 7, then holds at 7.
  - halted=1 and a single wrap pulse on entry to HALT.
  - en toggling and oneshot=0 have no effect.
  - load_val=2 -> Q=2, halted=0, counting resumes.
- Simultaneous and mid-operation events:
  - rst and load in the same cycle -> Q=0.
  - Direction flip exactly at Q=MODULUS-1 with up=0 -> Q decrements to MODULUS-2, no wrap.
  - rst asserted while in HALT -> Q=0, halted=0.
- With GRAY_OUT_EN defined, WIDTH=3, MODULUS=8, counting up:
  - gray sequence 0,1,3,2,6,7,5,4,0.
  - Without the macro, the gray port is absent and the design elaborates cleanly.
